// File: rtl/dcache_pkg.sv
// Shared definitions for the D-cache data SRAM controller: size defaults,
// controller state encoding and the line-index width helper.
package dcache_pkg;

  localparam int unsigned ADDR_WIDTH_DEF = 9;
  localparam int unsigned DATA_WIDTH_DEF = 32;
  localparam int unsigned BE_WIDTH_DEF   = DATA_WIDTH_DEF / 8;
  localparam int unsigned LINE_WORDS_DEF = 8;

  typedef enum logic [1:0] {
    StIdle,
    StRefill,
    StDone
  } dcache_state_e;

  // Width of a line index: word address minus the word-in-line offset bits.
  function automatic int unsigned line_idx_width(input int unsigned addr_width,
                                                 input int unsigned line_words);
    return addr_width - $clog2(line_words);
  endfunction

endpackage

// File: rtl/dcache_fwd_merge.sv
// Byte-wise merge of a forwarded write into SRAM read data. Bytes whose
// forwarded enable is set come from the write, the rest from the SRAM.
module dcache_fwd_merge #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned BE_WIDTH   = DATA_WIDTH / 8
) (
  input  logic                  hit_i,
  input  logic [DATA_WIDTH-1:0] rd_data_i,
  input  logic [DATA_WIDTH-1:0] fwd_data_i,
  input  logic [BE_WIDTH-1:0]   fwd_be_i,
  output logic [DATA_WIDTH-1:0] data_o
);

  // Overlay forwarded bytes on the SRAM word.
  always_comb begin
    data_o = rd_data_i;
    for (int b = 0; b < BE_WIDTH; b++) begin
      if (hit_i && fwd_be_i[b]) begin
        data_o[8*b +: 8] = fwd_data_i[8*b +: 8];
      end
    end
  end

endmodule

// File: rtl/dcache_data_ctrl.sv
// D-cache data SRAM controller: arbitrates the single SRAM write port between
// line refills and CPU stores, drives the read port for loads and sequences
// refill bursts. Optional macro DCACHE_FWD_EN forwards a same-cycle write to a
// colliding load instead of retrying the load.
module dcache_data_ctrl
  import dcache_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int unsigned BE_WIDTH   = BE_WIDTH_DEF,
  parameter int unsigned LINE_WORDS = LINE_WORDS_DEF
) (
  input  logic                                                clk,
  input  logic                                                rst_n,
  input  logic                                                ld_req,
  input  logic [ADDR_WIDTH-1:0]                               ld_addr,
  output logic                                                ld_gnt,
  output logic                                                ld_rvalid,
  output logic [DATA_WIDTH-1:0]                               ld_rdata,
  input  logic                                                st_req,
  input  logic [ADDR_WIDTH-1:0]                               st_addr,
  input  logic [DATA_WIDTH-1:0]                               st_data,
  input  logic [BE_WIDTH-1:0]                                 st_be,
  output logic                                                st_gnt,
  input  logic                                                rf_start,
  input  logic [line_idx_width(ADDR_WIDTH, LINE_WORDS)-1:0]   rf_line,
  input  logic                                                rf_wvalid,
  input  logic [DATA_WIDTH-1:0]                               rf_wdata,
  output logic                                                rf_wready,
  output logic                                                rf_done,
  output logic                                                busy,
  output logic                                                sram_wr_en,
  output logic [ADDR_WIDTH-1:0]                               sram_wr_addr,
  output logic [DATA_WIDTH-1:0]                               sram_wr_data,
  output logic [BE_WIDTH-1:0]                                 sram_wr_byte_en,
  output logic [ADDR_WIDTH-1:0]                               sram_rd_addr,
  input  logic [DATA_WIDTH-1:0]                               sram_rd_data
);

  localparam int unsigned CntW  = $clog2(LINE_WORDS);
  localparam int unsigned LineW = line_idx_width(ADDR_WIDTH, LINE_WORDS);
  localparam logic [CntW-1:0] CntLast = CntW'(LINE_WORDS - 1);

  dcache_state_e          state_q, state_d;
  logic [CntW-1:0]        cnt_q, cnt_d;
  logic [LineW-1:0]       line_q, line_d;
  logic                   ld_rvalid_q;
  logic                   rf_wr;
  logic                   ld_in_line;
  logic                   wr_hit;
  logic [DATA_WIDTH-1:0]  rd_word;

  // Refill sequencing and store grant; refill owns the write port while active.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    line_d    = line_q;
    st_gnt    = 1'b0;
    rf_wready = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (rf_start) begin
          line_d  = rf_line;
          cnt_d   = '0;
          state_d = StRefill;
        end else begin
          st_gnt = st_req;
        end
      end
      StRefill: begin
        rf_wready = 1'b1;
        if (rf_wvalid) begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CntLast) begin
            state_d = StDone;
          end
        end
      end
      StDone: begin
        st_gnt  = st_req;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Write-port mux: a refill word wins, otherwise the granted store.
  always_comb begin
    rf_wr           = rf_wready & rf_wvalid;
    sram_wr_en      = st_gnt | rf_wr;
    sram_wr_addr    = rf_wr ? {line_q, cnt_q} : st_addr;
    sram_wr_data    = rf_wr ? rf_wdata : st_data;
    sram_wr_byte_en = rf_wr ? {BE_WIDTH{1'b1}} : st_be;
  end

  // Load grant: block loads into the line being refilled and, without
  // forwarding, loads that hit the word being written this cycle.
  always_comb begin
    sram_rd_addr = ld_addr;
    ld_in_line   = (state_q == StRefill) && (ld_addr[ADDR_WIDTH-1:CntW] == line_q);
    wr_hit       = sram_wr_en && (sram_wr_addr == ld_addr);
`ifdef DCACHE_FWD_EN
    ld_gnt       = ld_req & ~ld_in_line;
`else
    ld_gnt       = ld_req & ~ld_in_line & ~wr_hit;
`endif
  end

  // Controller state and load-valid pipeline.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      line_q      <= '0;
      ld_rvalid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      line_q      <= line_d;
      ld_rvalid_q <= ld_gnt;
    end
  end

`ifdef DCACHE_FWD_EN
  logic                  fwd_hit_q;
  logic [DATA_WIDTH-1:0] fwd_data_q;
  logic [BE_WIDTH-1:0]   fwd_be_q;

  // Capture the write that collides with a granted load.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fwd_hit_q  <= 1'b0;
      fwd_data_q <= '0;
      fwd_be_q   <= '0;
    end else begin
      fwd_hit_q <= ld_gnt & wr_hit;
      if (ld_gnt && wr_hit) begin
        fwd_data_q <= sram_wr_data;
        fwd_be_q   <= sram_wr_byte_en;
      end
    end
  end

  dcache_fwd_merge #(
    .DATA_WIDTH (DATA_WIDTH),
    .BE_WIDTH   (BE_WIDTH)
  ) u_fwd_merge (
    .hit_i      (fwd_hit_q),
    .rd_data_i  (sram_rd_data),
    .fwd_data_i (fwd_data_q),
    .fwd_be_i   (fwd_be_q),
    .data_o     (rd_word)
  );
`else
  assign rd_word = sram_rd_data;
`endif

  // SRAM read data lands one cycle after the grant; hold zero otherwise.
  always_comb begin
    ld_rvalid = ld_rvalid_q;
    ld_rdata  = ld_rvalid_q ? rd_word : '0;
    rf_done   = (state_q == StDone);
    busy      = (state_q != StIdle);
  end

endmodule

// File: tb/tb_dcache_data_ctrl.sv
// Testbench for dcache_data_ctrl: behavioural SRAM, directed stimulus and a
// scoreboard of expected SRAM writes and load data checked by a monitor.
module tb_dcache_data_ctrl;

  logic        clk;
  logic        rst_n;
  logic        ld_req;
  logic [8:0]  ld_addr;
  logic        ld_gnt;
  logic        ld_rvalid;
  logic [31:0] ld_rdata;
  logic        st_req;
  logic [8:0]  st_addr;
  logic [31:0] st_data;
  logic [3:0]  st_be;
  logic        st_gnt;
  logic        rf_start;
  logic [5:0]  rf_line;
  logic        rf_wvalid;
  logic [31:0] rf_wdata;
  logic        rf_wready;
  logic        rf_done;
  logic        busy;
  logic        sram_wr_en;
  logic [8:0]  sram_wr_addr;
  logic [31:0] sram_wr_data;
  logic [3:0]  sram_wr_byte_en;
  logic [8:0]  sram_rd_addr;
  logic [31:0] sram_rd_data;

  int n_cmp;
  int n_err;
  int done_cnt;

  logic [44:0] wq[$];
  logic [31:0] lq[$];

  logic [31:0] mem [512];

  dcache_data_ctrl u_dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .ld_req          (ld_req),
    .ld_addr         (ld_addr),
    .ld_gnt          (ld_gnt),
    .ld_rvalid       (ld_rvalid),
    .ld_rdata        (ld_rdata),
    .st_req          (st_req),
    .st_addr         (st_addr),
    .st_data         (st_data),
    .st_be           (st_be),
    .st_gnt          (st_gnt),
    .rf_start        (rf_start),
    .rf_line         (rf_line),
    .rf_wvalid       (rf_wvalid),
    .rf_wdata        (rf_wdata),
    .rf_wready       (rf_wready),
    .rf_done         (rf_done),
    .busy            (busy),
    .sram_wr_en      (sram_wr_en),
    .sram_wr_addr    (sram_wr_addr),
    .sram_wr_data    (sram_wr_data),
    .sram_wr_byte_en (sram_wr_byte_en),
    .sram_rd_addr    (sram_rd_addr),
    .sram_rd_data    (sram_rd_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // SRAM model: byte-enabled write, registered read returning old data on collision.
  initial begin
    for (int i = 0; i < 512; i++) mem[i] = '0;
    sram_rd_data = '0;
  end

  always @(posedge clk) begin
    sram_rd_data <= mem[sram_rd_addr];
    if (sram_wr_en) begin
      for (int b = 0; b < 4; b++) begin
        if (sram_wr_byte_en[b]) mem[sram_wr_addr][8*b +: 8] <= sram_wr_data[8*b +: 8];
      end
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: pop and compare whenever the DUT writes the SRAM or returns load data.
  always @(negedge clk) begin
    if (rst_n) begin
      if (sram_wr_en) begin
        if (wq.size() == 0) check("unexpected_write", {19'd0, sram_wr_addr, sram_wr_data,
                                                       sram_wr_byte_en}, 64'd0);
        else check("sram_write", {19'd0, sram_wr_addr, sram_wr_data, sram_wr_byte_en},
                   {19'd0, wq.pop_front()});
      end
      if (ld_rvalid) begin
        if (lq.size() == 0) check("unexpected_load", {32'd0, ld_rdata}, 64'd0);
        else check("load_data", {32'd0, ld_rdata}, {32'd0, lq.pop_front()});
      end
      if (rf_done) done_cnt++;
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    ld_req = 0; ld_addr = '0; st_req = 0; st_addr = '0; st_data = '0; st_be = '0;
    rf_start = 0; rf_line = '0; rf_wvalid = 0; rf_wdata = '0;
  endtask

  initial begin
    n_cmp = 0; n_err = 0; done_cnt = 0;
    rst_n = 0;
    clr();
    @(negedge clk);
    @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_rvalid", ld_rvalid, 0);
    check("rst_rdata", ld_rdata, 0);
    check("rst_done", rf_done, 0);
    cyc();
    rst_n = 1;

    // Partial store then load back.
    cyc();
    st_req = 1; st_addr = 9'h005; st_data = 32'hA5A5A5A5; st_be = 4'b0011;
    wq.push_back({9'h005, 32'hA5A5A5A5, 4'b0011});
    @(negedge clk);
    check("st_gnt_idle", st_gnt, 1);
    cyc();
    clr();
    cyc();
    ld_req = 1; ld_addr = 9'h005;
    lq.push_back(32'h0000A5A5);
    @(negedge clk);
    check("ld_gnt_idle", ld_gnt, 1);
    cyc();
    clr();
    @(negedge clk);
    check("ld_rvalid_lat", ld_rvalid, 1);

    // Refill start collides with a store request: refill wins.
    cyc();
    rf_start = 1; rf_line = 6'h03;
    st_req = 1; st_addr = 9'h020; st_data = 32'hDEADBEEF; st_be = 4'hF;
    @(negedge clk);
    check("start_st_gnt", st_gnt, 0);
    check("start_busy", busy, 0);
    cyc();
    rf_start = 0;
    ld_req = 1; ld_addr = 9'h01A;
    @(negedge clk);
    check("rf_busy", busy, 1);
    check("rf_wready", rf_wready, 1);
    check("rf_st_blocked", st_gnt, 0);
    check("rf_ld_in_line", ld_gnt, 0);
    for (int i = 0; i < 8; i++) begin
      cyc();
      ld_req = (i == 2); ld_addr = 9'h040;
      rf_wvalid = 1; rf_wdata = 32'h100 + i;
      wq.push_back({9'(9'h018 + i), 32'h100 + i, 4'hF});
      if (i == 2) lq.push_back(32'h0);
      @(negedge clk);
      check("rf_word_busy", busy, 1);
      check("rf_word_st_gnt", st_gnt, 0);
      if (i == 2) check("rf_ld_other_line", ld_gnt, 1);
      if (i % 2 == 1 && i < 7) begin
        cyc();
        rf_wvalid = 0; ld_req = 0;
        @(negedge clk);
        check("rf_gap_done", rf_done, 0);
      end
    end
    cyc();
    rf_wvalid = 0; ld_req = 0;
    wq.push_back({9'h020, 32'hDEADBEEF, 4'hF});
    @(negedge clk);
    check("done_pulse", rf_done, 1);
    check("done_busy", busy, 1);
    check("done_st_gnt", st_gnt, 1);
    cyc();
    clr();
    @(negedge clk);
    check("post_done", rf_done, 0);
    check("post_busy", busy, 0);

    // Read back refilled words and the deferred store.
    cyc(); ld_req = 1; ld_addr = 9'h018; lq.push_back(32'h100);
    cyc(); ld_addr = 9'h01F; lq.push_back(32'h107);
    cyc(); ld_addr = 9'h01C; lq.push_back(32'h104);
    cyc(); ld_addr = 9'h020; lq.push_back(32'hDEADBEEF);
    cyc(); clr();

    // Same-cycle store and load to one word.
    cyc();
    st_req = 1; st_addr = 9'h010; st_data = 32'h11223344; st_be = 4'hF;
    ld_req = 1; ld_addr = 9'h010;
    wq.push_back({9'h010, 32'h11223344, 4'hF});
`ifdef DCACHE_FWD_EN
    lq.push_back(32'h11223344);
    @(negedge clk);
    check("coll_ld_gnt_fwd", ld_gnt, 1);
    cyc();
    clr();
`else
    @(negedge clk);
    check("coll_ld_gnt", ld_gnt, 0);
    cyc();
    st_req = 0;
    lq.push_back(32'h11223344);
    @(negedge clk);
    check("retry_ld_gnt", ld_gnt, 1);
    cyc();
    clr();
`endif
    cyc();

    // Reset in the middle of a refill.
    cyc();
    rf_start = 1; rf_line = 6'h05;
    cyc();
    rf_start = 0;
    for (int i = 0; i < 4; i++) begin
      rf_wvalid = 1; rf_wdata = 32'h200 + i;
      wq.push_back({9'(9'h028 + i), 32'h200 + i, 4'hF});
      cyc();
    end
    rf_wdata = 32'h204;
    rst_n = 0;
    @(negedge clk);
    check("abort_busy", busy, 0);
    check("abort_wready", rf_wready, 0);
    check("abort_wr_en", sram_wr_en, 0);
    check("abort_done", rf_done, 0);
    check("abort_rvalid", ld_rvalid, 0);
    check("abort_rdata", ld_rdata, 0);
    check("abort_st_gnt", st_gnt, 0);
    cyc();
    rst_n = 1;
    @(negedge clk);
    check("idle_wvalid_ignored", sram_wr_en, 0);
    check("idle_busy", busy, 0);
    cyc();
    clr();
    cyc();
    cyc();
    @(negedge clk);
    check("done_count", done_cnt, 1);
    check("wq_drained", wq.size(), 0);
    check("lq_drained", lq.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
